// File: rtl/axi4_slave_mem_if.sv
// rtl/axi4_slave_mem_if.sv - AXI4 pin bundle between the bench master and axi4_slave_mem
interface axi4_slave_mem_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 subordinate RAM, INCR/FIXED bursts; define AXI_MEM_STALL_EN for LFSR backpressure
module axi4_slave_mem #(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] MEM_BASE  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    axi4_slave_mem_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_SH = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - MEM_BASE;
        return off >> OFF_SH;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + (ADDR_W'(1) << size);
    endfunction

    // WRAP, reserved burst or oversize beats fail the whole burst; otherwise range decides
    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] idx,
                                             input logic [2:0] size, input logic [1:0] burst);
        if (burst[1] || size > 3'(OFF_SH)) return SLVERR;
        if (idx >= ADDR_W'(MEM_WORDS))    return DECERR;
        return OKAY;
    endfunction

    logic stall;
`ifdef AXI_MEM_STALL_EN
    logic [15:0] lfsr;
    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    logic unused_sideband;
    assign unused_sideband = ^{bus.awlock, bus.awcache, bus.awprot, bus.awqos, bus.awregion,
                               bus.arlock, bus.arcache, bus.arprot, bus.arqos, bus.arregion};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    wstate_t           wstate;
    logic              aw_rdy_q, w_rdy_q, bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q, w_acc, w_resp;
    logic [ADDR_W-1:0] w_addr, w_idx;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              aw_hs, w_hs;

    assign bus.awready = aw_rdy_q & ~stall;
    assign bus.wready  = w_rdy_q & ~stall;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign aw_hs       = bus.awvalid & bus.awready;
    assign w_hs        = bus.wvalid & bus.wready;
    assign w_idx       = word_idx(w_addr);
    assign w_resp      = beat_resp(w_idx, w_size, w_burst);

    // Write FSM: accept AW, commit strobed beats, hold B until accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate   <= W_IDLE;
            aw_rdy_q <= 1'b1;
            w_rdy_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= OKAY;
            w_acc    <= OKAY;
            w_addr   <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
        end else begin
            case (wstate)
                W_IDLE: if (aw_hs) begin
                    bid_q    <= bus.awid;
                    w_addr   <= bus.awaddr;
                    w_len    <= bus.awlen;
                    w_size   <= bus.awsize;
                    w_burst  <= bus.awburst;
                    w_cnt    <= '0;
                    w_acc    <= OKAY;
                    aw_rdy_q <= 1'b0;
                    w_rdy_q  <= 1'b1;
                    wstate   <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    if (w_resp == OKAY) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (bus.wstrb[b]) mem[w_idx[IDX_W-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
                        end
                    end else if (w_acc == OKAY) begin
                        w_acc <= w_resp;
                    end
                    w_addr <= next_addr(w_addr, w_size, w_burst);
                    w_cnt  <= w_cnt + 8'd1;
                    if (bus.wlast) begin
                        bresp_q  <= (w_cnt != w_len) ? SLVERR : (w_acc != OKAY) ? w_acc : w_resp;
                        w_rdy_q  <= 1'b0;
                        bvalid_q <= ~stall;
                        wstate   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid_q && bus.bready) begin
                        bvalid_q <= 1'b0;
                        aw_rdy_q <= 1'b1;
                        wstate   <= W_IDLE;
                    end else if (!bvalid_q && !stall) begin
                        bvalid_q <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    typedef enum logic {R_IDLE, R_BURST} rstate_t;
    rstate_t           rstate;
    logic              ar_rdy_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q, r_burst, ld_burst, ld_resp;
    logic [ADDR_W-1:0] r_addr, ld_addr, ld_idx;
    logic [7:0]        r_len, r_cnt, ld_len, ld_cnt;
    logic [2:0]        r_size, ld_size;
    logic              ar_hs, r_hs;

    assign bus.arready = ar_rdy_q & ~stall;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign ar_hs       = bus.arvalid & bus.arready;
    assign r_hs        = rvalid_q & bus.rready;

    // Beat to load next: fresh request, the following beat, or a stalled pending beat
    always_comb begin
        ld_addr  = r_addr;
        ld_cnt   = r_cnt;
        ld_len   = r_len;
        ld_size  = r_size;
        ld_burst = r_burst;
        if (rstate == R_IDLE) begin
            ld_addr  = bus.araddr;
            ld_cnt   = '0;
            ld_len   = bus.arlen;
            ld_size  = bus.arsize;
            ld_burst = bus.arburst;
        end else if (r_hs) begin
            ld_addr = next_addr(r_addr, r_size, r_burst);
            ld_cnt  = r_cnt + 8'd1;
        end
        ld_idx  = word_idx(ld_addr);
        ld_resp = beat_resp(ld_idx, ld_size, ld_burst);
    end

    // Read FSM: registered RAM read gives old data on a same-cycle write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate   <= R_IDLE;
            ar_rdy_q <= 1'b1;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
        end else begin
            if ((rstate == R_IDLE && ar_hs) ||
                (rstate == R_BURST && ((r_hs && !rlast_q) || !rvalid_q))) begin
                r_addr <= ld_addr;
                r_cnt  <= ld_cnt;
                if (!stall) begin
                    rdata_q <= (ld_resp == OKAY) ? mem[ld_idx[IDX_W-1:0]] : '0;
                    rresp_q <= ld_resp;
                    rlast_q <= (ld_cnt == ld_len);
                end
                rvalid_q <= ~stall;
            end
            case (rstate)
                R_IDLE: if (ar_hs) begin
                    rid_q    <= bus.arid;
                    r_len    <= bus.arlen;
                    r_size   <= bus.arsize;
                    r_burst  <= bus.arburst;
                    ar_rdy_q <= 1'b0;
                    rstate   <= R_BURST;
                end
                R_BURST: if (r_hs && rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    ar_rdy_q <= 1'b1;
                    rstate   <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb/tb_axi4_slave_mem.sv - directed bench for axi4_slave_mem
module tb_axi4_slave_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    axi4_slave_mem_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) bus ();

    axi4_slave_mem #(.ID_W(4), .ADDR_W(32), .DATA_W(64), .MEM_WORDS(4096), .MEM_BASE(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] rdq [256];
    logic [1:0]  rrq [256];
    logic        rlq [256];
    logic [3:0]  ridq [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                               input logic [63:0] d0, input logic [7:0] strb,
                               output logic [1:0] resp, output logic [3:0] bid_o);
        int cyc;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        cyc = 0;
        while (!bus.awready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("aw_ready", bus.awready, 1'b1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.wdata = d0 + 64'(i); bus.wstrb = strb; bus.wlast = (i == nbeats - 1); bus.wvalid = 1'b1;
            cyc = 0;
            while (!bus.wready && cyc < 50) begin @(posedge clk); #1; cyc++; end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        cyc = 0;
        while (!bus.bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("b_valid", bus.bvalid, 1'b1);
        resp = bus.bresp; bid_o = bus.bid;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int hold_beat,
                              output int n);
        int cyc;
        logic [63:0] hold;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        cyc = 0;
        while (!bus.arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("ar_ready", bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        n = 0; cyc = 0;
        while (n <= int'(len) && cyc < 600) begin
            if (bus.rvalid) begin
                if (n == hold_beat) begin
                    bus.rready = 1'b0;
                    hold = bus.rdata;
                    repeat (3) begin
                        @(posedge clk); #1;
                        chk("hold_data", bus.rdata, hold);
                        chk("hold_valid", bus.rvalid, 1'b1);
                        chk("hold_last", bus.rlast, 1'b0);
                    end
                    bus.rready = 1'b1;
                end
                rdq[n] = bus.rdata; rrq[n] = bus.rresp; rlq[n] = bus.rlast; ridq[n] = bus.rid;
                n++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [1:0] resp;
        logic [3:0] bid_o;
        int n;

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", bus.awready, 1'b1);
        chk("rst_arready", bus.arready, 1'b1);
        chk("rst_wready", bus.wready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rlast", bus.rlast, 1'b0);
        chk("rst_bid_bresp", {bus.bid, bus.bresp}, '0);
        chk("rst_rid_rresp", {bus.rid, bus.rresp}, '0);
        chk("rst_rdata", bus.rdata, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single full-strobe write then read back
        write_burst(4'h1, 32'h40, 8'd0, 3'd3, 2'b01, 1, 64'h1122334455667788, 8'hFF, resp, bid_o);
        chk("single_bresp", resp, 2'b00);
        chk("single_bid", bid_o, 4'h1);
        read_burst(4'h2, 32'h40, 8'd0, 3'd3, 2'b01, -1, n);
        chk("single_nbeats", n, 1);
        chk("single_rdata", rdq[0], 64'h1122334455667788);
        chk("single_rresp", rrq[0], 2'b00);
        chk("single_rlast", rlq[0], 1'b1);
        chk("single_rid", ridq[0], 4'h2);

        // partial strobe merges low word only
        write_burst(4'h1, 32'h40, 8'd0, 3'd3, 2'b01, 1, 64'hAAAAAAAABBBBBBBB, 8'h0F, resp, bid_o);
        chk("strb_bresp", resp, 2'b00);
        read_burst(4'h2, 32'h40, 8'd0, 3'd3, 2'b01, -1, n);
        chk("strb_rdata", rdq[0], 64'h11223344BBBBBBBB);

        // INCR burst write 0x100..0x118, read back with rready held low on beat 2
        write_burst(4'h3, 32'h100, 8'd3, 3'd3, 2'b01, 4, 64'h0100000000000000, 8'hFF, resp, bid_o);
        chk("incr_w_bresp", resp, 2'b00);
        read_burst(4'h4, 32'h100, 8'd3, 3'd3, 2'b01, 1, n);
        chk("incr_nbeats", n, 4);
        chk("incr_b0", rdq[0], 64'h0100000000000000);
        chk("incr_b1", rdq[1], 64'h0100000000000001);
        chk("incr_b2", rdq[2], 64'h0100000000000002);
        chk("incr_b3", rdq[3], 64'h0100000000000003);
        chk("incr_rlast_pattern", {rlq[0], rlq[1], rlq[2], rlq[3]}, 4'b0001);

        // out of range read
        read_burst(4'h5, 32'h8000, 8'd0, 3'd3, 2'b01, -1, n);
        chk("oor_rresp", rrq[0], 2'b11);
        chk("oor_rdata", rdq[0], 64'h0);
        chk("oor_rlast", rlq[0], 1'b1);

        // WRAP write rejected, memory unchanged; WRAP read errors with zero data
        write_burst(4'h6, 32'h40, 8'd1, 3'd3, 2'b10, 2, 64'hDEADBEEFDEADBEEF, 8'hFF, resp, bid_o);
        chk("wrap_bresp", resp, 2'b10);
        read_burst(4'h2, 32'h40, 8'd0, 3'd3, 2'b01, -1, n);
        chk("wrap_mem_kept", rdq[0], 64'h11223344BBBBBBBB);
        read_burst(4'h7, 32'h100, 8'd1, 3'd3, 2'b10, -1, n);
        chk("wrap_r_nbeats", n, 2);
        chk("wrap_r_resp", {rrq[0], rrq[1]}, 4'b1010);
        chk("wrap_r_data", rdq[1], 64'h0);

        // early wlast on a two-beat burst
        write_burst(4'h5, 32'h300, 8'd1, 3'd3, 2'b01, 1, 64'h5, 8'hFF, resp, bid_o);
        chk("early_wlast_bresp", resp, 2'b10);
        chk("early_wlast_bid", bid_o, 4'h5);

        // FIXED burst: every beat lands on the same word
        write_burst(4'h8, 32'h600, 8'd2, 3'd3, 2'b00, 3, 64'h6000000000000000, 8'hFF, resp, bid_o);
        chk("fixed_bresp", resp, 2'b00);
        read_burst(4'h9, 32'h600, 8'd1, 3'd3, 2'b00, -1, n);
        chk("fixed_b0", rdq[0], 64'h6000000000000002);
        chk("fixed_b1", rdq[1], 64'h6000000000000002);
        chk("fixed_rlast", {rlq[0], rlq[1]}, 2'b01);

        // same-cycle read and write of 0x200
        write_burst(4'h1, 32'h200, 8'd0, 3'd3, 2'b01, 1, 64'h0123456789ABCDEF, 8'hFF, resp, bid_o);
        bus.awid = 4'h6; bus.awaddr = 32'h200; bus.awlen = 8'd0; bus.awsize = 3'd3; bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        chk("rw_wready", bus.wready, 1'b1);
        bus.wdata = 64'hFEDCBA9876543210; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        bus.arid = 4'hA; bus.araddr = 32'h200; bus.arlen = 8'd0; bus.arsize = 3'd3; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
        chk("rw_rvalid", bus.rvalid, 1'b1);
        chk("rw_old_data", bus.rdata, 64'h0123456789ABCDEF);
        chk("rw_bvalid", bus.bvalid, 1'b1);
        chk("rw_bresp", bus.bresp, 2'b00);
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0; bus.bready = 1'b0;
        read_burst(4'h2, 32'h200, 8'd0, 3'd3, 2'b01, -1, n);
        chk("rw_new_data", rdq[0], 64'hFEDCBA9876543210);

        // reset during beat 3 of an 8-beat read
        bus.arid = 4'hB; bus.araddr = 32'h100; bus.arlen = 8'd7; bus.arsize = 3'd3; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_beat3", bus.rdata, 64'h0100000000000002);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_rvalid", bus.rvalid, 1'b0);
        chk("rst_mid_arready", bus.arready, 1'b1);
        chk("rst_mid_rlast", bus.rlast, 1'b0);
        rst_n = 1'b1;
        bus.rready = 1'b0;
        @(posedge clk); #1;
        write_burst(4'h7, 32'h500, 8'd1, 3'd3, 2'b01, 2, 64'h5000000000000000, 8'hFF, resp, bid_o);
        chk("post_rst_bresp", resp, 2'b00);
        chk("post_rst_bid", bid_o, 4'h7);
        read_burst(4'hC, 32'h500, 8'd1, 3'd3, 2'b01, -1, n);
        chk("post_rst_nbeats", n, 2);
        chk("post_rst_b1", rdq[1], 64'h5000000000000001);
        chk("post_rst_resp", {rrq[0], rrq[1]}, 4'b0000);
        chk("post_rst_rid", ridq[1], 4'hC);
        read_burst(4'h2, 32'h40, 8'd0, 3'd3, 2'b01, -1, n);
        chk("post_rst_mem_kept", rdq[0], 64'h11223344BBBBBBBB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
